// File: rtl/ps_serializer.sv
// Bit-rate parallel-to-serial transmitter: COMMA sync burst after reset, then
// MSB-first lane data with a valid/ready handshake and IDLE fill.
module ps_serializer #(
    parameter int              WIDTH      = 8,
    parameter int              LANES      = 1,
    parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE      = 8'h7C,
    parameter int              SYNC_WORDS = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   force_idle,
    output logic                   in_ready,
    output logic [LANES-1:0]       serial_out,
    output logic                   word_start,
    output logic                   sync_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = $clog2(SYNC_WORDS + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_WORDS - 1);

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic [CW-1:0]                 cnt;
    logic [SW-1:0]                 sync_cnt;
    logic [LANES-1:0][WIDTH-1:0]   shreg;
    logic [LANES-1:0][WIDTH-1:0]   load_word;
    logic                          at_load;
    logic                          started;

    assign at_load = (cnt == LAST_BIT);

    always_ff @(posedge clk_32f) begin
        if (reset) state <= ST_SYNC;
        else       state <= next_state;
    end

    // The RUN transition coincides with the last COMMA load.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        load_word  = '0;
        if (state == ST_SYNC) begin
            for (int k = 0; k < LANES; k++) load_word[k] = COMMA;
            if (at_load && sync_cnt == LAST_SYNC) next_state = ST_RUN;
        end else begin
            in_ready = at_load && !force_idle && !reset;
            for (int k = 0; k < LANES; k++)
                load_word[k] = (!force_idle && in_valid) ? in_data[k*WIDTH +: WIDTH] : IDLE;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt       <= LAST_BIT;
            sync_cnt  <= '0;
            shreg     <= '0;
            sync_done <= 1'b0;
            started   <= 1'b0;
        end else if (at_load) begin
            cnt     <= '0;
            shreg   <= load_word;
            started <= 1'b1;
            if (state == ST_SYNC) sync_cnt  <= sync_cnt + 1'b1;
            else                  sync_done <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < LANES; k++)
                shreg[k] <= {shreg[k][WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) serial_out[k] = shreg[k][WIDTH-1];
    end

    assign word_start = (cnt == '0) && started;

endmodule

// File: tb/tb_ps_serializer.sv
// Directed bench for ps_serializer: single-lane and dual-lane instances share
// stimulus and are checked every cycle against a word-level behavioural model.
module tb_ps_serializer;

    localparam int         W     = 8;
    localparam int         SYNC  = 4;
    localparam logic [7:0] COMMA = 8'hBC;
    localparam logic [7:0] IDLE  = 8'h7C;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        force_idle;

    logic       ready1, ws1, sd1;
    logic [0:0] ser1;
    logic       ready2, ws2, sd2;
    logic [1:0] ser2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_32f = ~clk_32f;

    ps_serializer #(.WIDTH(8), .LANES(1), .COMMA(COMMA), .IDLE(IDLE), .SYNC_WORDS(SYNC)) dut1 (
        .clk_32f(clk_32f), .reset(reset), .in_valid(in_valid), .in_data(in_data[7:0]),
        .force_idle(force_idle), .in_ready(ready1), .serial_out(ser1),
        .word_start(ws1), .sync_done(sd1)
    );

    ps_serializer #(.WIDTH(8), .LANES(2), .COMMA(COMMA), .IDLE(IDLE), .SYNC_WORDS(SYNC)) dut2 (
        .clk_32f(clk_32f), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .force_idle(force_idle), .in_ready(ready2), .serial_out(ser2),
        .word_start(ws2), .sync_done(sd2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mn = edges since reset released; word k starts at edge k*W+1.
    int              mn = 0;
    logic            mdl_live = 1'b0;
    logic            mdl_sd;
    logic [1:0][7:0] mdl_word;

    always @(posedge clk_32f) begin
        mdl_live <= 1'b1;
        if (reset) begin
            mn       <= 0;
            mdl_sd   <= 1'b0;
            mdl_word <= '0;
        end else begin
            if (mn % W == 0) begin
                if (mn / W < SYNC) begin
                    mdl_word <= {COMMA, COMMA};
                end else begin
                    mdl_sd <= 1'b1;
                    for (int k = 0; k < 2; k++)
                        mdl_word[k] <= (!force_idle && in_valid) ? in_data[k*8 +: 8] : IDLE;
                end
            end
            mn <= mn + 1;
        end
    end

    logic [31:0] rx1;
    logic [7:0]  rx2_l0, rx2_l1;

    always @(negedge clk_32f) begin
        logic [1:0] exp_ser;
        logic       exp_ws, exp_rdy;
        int         b;
        if (mdl_live) begin
            if (mn == 0) begin
                exp_ser = 2'b00;
                exp_ws  = 1'b0;
            end else begin
                b       = (mn - 1) % W;
                exp_ser = {mdl_word[1][7-b], mdl_word[0][7-b]};
                exp_ws  = (b == 0);
            end
            exp_rdy = !reset && (mn % W == 0) && (mn / W >= SYNC) && !force_idle;
            chk("ser1",   {31'b0, ser1[0]}, {31'b0, exp_ser[0]});
            chk("ws1",    {31'b0, ws1},     {31'b0, exp_ws});
            chk("sd1",    {31'b0, sd1},     {31'b0, mdl_sd});
            chk("ready1", {31'b0, ready1},  {31'b0, exp_rdy});
            chk("ser2",   {30'b0, ser2},    {30'b0, exp_ser});
            chk("ws2",    {31'b0, ws2},     {31'b0, exp_ws});
            chk("sd2",    {31'b0, sd2},     {31'b0, mdl_sd});
            chk("ready2", {31'b0, ready2},  {31'b0, exp_rdy});
            rx1    <= {rx1[30:0], ser1[0]};
            rx2_l0 <= {rx2_l0[6:0], ser2[0]};
            rx2_l1 <= {rx2_l1[6:0], ser2[1]};
        end
    end

    // Advance to the cycle where the last bit of a word has just been shown.
    task automatic wait_word_end();
        int c = 0;
        do begin
            @(negedge clk_32f);
            #1;
            c++;
        end while ((mn % W != 0 || mn == 0) && c < 40);
        chk("word_end_bound", mn % W, 0);
    endtask

    logic [7:0] bursts [3] = '{8'h00, 8'hFF, 8'h3C};

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        force_idle = 1'b0;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        #1;
        chk("reset_ser",  {31'b0, ser1[0]}, 0);
        chk("reset_sd",   {31'b0, sd1}, 0);
        reset = 1'b0;

        // Sync burst
        for (int k = 0; k < SYNC; k++) begin
            wait_word_end();
            chk("comma_word", {24'b0, rx1[7:0]}, 32'hBC);
        end
        chk("sd_before_run", {31'b0, sd1}, 0);
        chk("ready_first_run", {31'b0, ready1}, 1);
        wait_word_end();
        chk("idle_word", {24'b0, rx1[7:0]}, 32'h7C);
        chk("sd_after_run", {31'b0, sd1}, 1);

        // Single word, two lanes
        in_valid = 1'b1;
        in_data  = 16'hBCA5;
        @(posedge clk_32f);
        #1;
        in_valid = 1'b0;
        wait_word_end();
        chk("a5_lane", {24'b0, rx1[7:0]}, 32'hA5);
        chk("dual_l0", {24'b0, rx2_l0}, 32'hA5);
        chk("dual_l1", {24'b0, rx2_l1}, 32'hBC);
        wait_word_end();
        chk("idle_after_a5", {24'b0, rx1[7:0]}, 32'h7C);

        // Back-to-back words
        for (int i = 0; i < 3; i++) begin
            in_data  = {8'h00, bursts[i]};
            in_valid = 1'b1;
            @(posedge clk_32f);
            #1;
            if (i < 2) begin
                repeat (7) @(posedge clk_32f);
                #1;
            end
        end
        in_valid = 1'b0;
        wait_word_end();
        chk("burst24", {8'b0, rx1[23:0]}, 32'h0000FF3C);

        // force_idle holds off a pending word
        force_idle = 1'b1;
        in_valid   = 1'b1;
        in_data    = 16'h0055;
        wait_word_end();
        chk("forced_idle1", {24'b0, rx1[7:0]}, 32'h7C);
        wait_word_end();
        chk("forced_idle2", {24'b0, rx1[7:0]}, 32'h7C);
        chk("forced_ready", {31'b0, ready1}, 0);
        force_idle = 1'b0;
        #1;
        chk("released_ready", {31'b0, ready1}, 1);
        @(posedge clk_32f);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        force_idle = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        force_idle = 1'b0;
        wait_word_end();
        chk("word_55", {24'b0, rx1[7:0]}, 32'h55);

        // Reset in the middle of a data word
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        @(posedge clk_32f);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk_32f);
        #1;
        reset = 1'b1;
        @(posedge clk_32f);
        @(negedge clk_32f);
        #1;
        chk("midword_reset_ser", {31'b0, ser1[0]}, 0);
        chk("midword_reset_sd",  {31'b0, sd1}, 0);
        reset = 1'b0;
        for (int k = 0; k < SYNC; k++) begin
            wait_word_end();
            chk("resync_comma", {24'b0, rx1[7:0]}, 32'hBC);
        end
        chk("resync_sd0", {31'b0, sd1}, 0);
        wait_word_end();
        chk("resync_idle", {24'b0, rx1[7:0]}, 32'h7C);
        chk("resync_sd1", {31'b0, sd1}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
